// File: rtl/switch_pkg.sv
// switch_pkg: shared constants and types for the N-port address switch.
//   - default parameter values for switch_nport
//   - port_w(): width of the port index derived from the port count
//   - pkt_t: the {addr, data} packet layout (default widths) stored in
//     each output FIFO
package switch_pkg;

  localparam int NUM_PORTS_DEF  = 4;
  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DROP_CNT_W     = 16;

  // Number of address MSBs that select the destination port.
  function automatic int port_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } pkt_t;

endpackage

// File: rtl/switch_fifo.sv
// switch_fifo: synchronous FIFO with extra-MSB pointers.
//   clk, rst     : clock, synchronous active-high reset (pointers only)
//   push, wdata  : write request; ignored while full
//   pop, rdata   : read request; rdata always shows the head entry
//   full, empty  : occupancy flags
module switch_fifo
  import switch_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  // Pointers wrap modulo 2*DEPTH; the MSB distinguishes full from empty.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign wr_en = push && !full && !rst;
  assign rd_en = pop && !empty && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/switch_nport.sv
// switch_nport: routes {addr, data} packets to one of NUM_PORTS output
// FIFOs selected by the address MSBs.
//   clk, rst          : clock, synchronous active-high reset
//   addr, data, vld   : input packet; rdy accepts it (vld && rdy)
//   out_addr/out_data : per-port head packet, port p at [p*W +: W]
//   out_vld, out_rdy  : per-port handshake
//   drop_cnt          : per-port saturating drop counters (SWITCH_DROP_EN only)
// Build option SWITCH_DROP_EN: rdy is tied high and packets for a full FIFO
// are discarded and counted instead of back-pressuring the input.
module switch_nport
  import switch_pkg::*;
#(
  parameter int NUM_PORTS  = NUM_PORTS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data,
  input  logic                        vld,
  output logic                        rdy,
  output logic [NUM_PORTS*ADDR_W-1:0] out_addr,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0]        out_vld,
  input  logic [NUM_PORTS-1:0]        out_rdy
`ifdef SWITCH_DROP_EN
  ,
  output logic [NUM_PORTS*DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam int PW = port_w(NUM_PORTS);
  localparam int PKT_W = ADDR_W + DATA_W;

  logic [PW-1:0]        dest;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;

  assign dest = addr[ADDR_W-1 -: PW];

  // rdy depends only on the FIFO addressed by the presented packet, so a
  // stalled port never blocks traffic to other ports.
`ifdef SWITCH_DROP_EN
  assign rdy = 1'b1;
`else
  assign rdy = !full[dest];
`endif

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [PKT_W-1:0] head;

      assign push[p]    = vld && rdy && (dest == PW'(p));
      assign pop[p]     = out_rdy[p] && !empty[p];
      assign out_vld[p] = !empty[p];
      assign out_addr[p*ADDR_W +: ADDR_W] = head[PKT_W-1 -: ADDR_W];
      assign out_data[p*DATA_W +: DATA_W] = head[DATA_W-1:0];

      switch_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[p]),
        .pop   (pop[p]),
        .wdata ({addr, data}),
        .rdata (head),
        .full  (full[p]),
        .empty (empty[p])
      );

`ifdef SWITCH_DROP_EN
      logic [DROP_CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (push[p] && full[p] && (cnt != {DROP_CNT_W{1'b1}})) begin
          cnt <= cnt + DROP_CNT_W'(1);
        end
      end

      assign drop_cnt[p*DROP_CNT_W +: DROP_CNT_W] = cnt;
`endif
    end
  endgenerate

endmodule

// File: doc/switch_nport.md
SWITCH_NPORT -- requirements
Module: switch_nport

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of output ports; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 8, address width in bits; ADDR_W >= log2(NUM_PORTS).
REQ-003 Parameter DATA_W, default 16, data width in bits.
REQ-004 Parameter FIFO_DEPTH, default 4, entries per output FIFO; power of two, >= 2.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 addr  input  ADDR_W  input packet address.
REQ-008 data  input  DATA_W  input packet data.
REQ-009 vld  input  1  input packet valid.
REQ-010 rdy  output  1  input ready; a packet transfers when vld && rdy.
REQ-011 out_addr  output  NUM_PORTS*ADDR_W  per-port address; port p in bits [p*ADDR_W +: ADDR_W].
REQ-012 out_data  output  NUM_PORTS*DATA_W  per-port data; packed the same way.
REQ-013 out_vld  output  NUM_PORTS  per-port valid.
REQ-014 out_rdy  input  NUM_PORTS  per-port downstream ready; transfer on out_vld[p] && out_rdy[p].

Function
REQ-015 Destination port SHALL be dest = addr[ADDR_W-1 -: log2(NUM_PORTS)]; with defaults, 0x00-0x3F go to port 0 and 0xC0-0xFF to port 3.
REQ-016 Each port SHALL own one FIFO_DEPTH-entry FIFO storing {addr, data} unmodified.
REQ-017 rdy SHALL equal !full of the FIFO selected by the current addr, independent of vld and of out_rdy (no combinational through-path).
REQ-018 An accepted packet SHALL be visible on its port's out_vld the cycle after acceptance (latency 1, including into an empty FIFO; no bypass).
REQ-019 Each port SHALL output packets in acceptance order; ports SHALL be independent (backpressure on one port SHALL NOT block ports whose FIFO is not full, except through REQ-017 for the packet currently presented).
REQ-020 out_vld[p] SHALL equal !empty of FIFO p; out_addr/out_data SHALL present the head entry and hold stable while out_vld[p] && !out_rdy[p].
REQ-021 Simultaneous push and pop on one FIFO SHALL leave the occupancy unchanged; on a full FIFO the push is refused per REQ-017 even if a pop occurs that cycle.
REQ-022 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full when the indices match and the MSBs differ, empty when they are equal.
REQ-023 out_addr/out_data SHALL be don't-care while out_vld[p] is low.

Reset
REQ-024 While rst is high at a rising edge, every FIFO SHALL be emptied (pointers to 0), out_vld SHALL be 0, and no push or pop SHALL occur, including mid-transfer.
REQ-025 During and after reset, rdy SHALL be 1 (all FIFOs empty); data storage needs no reset.
REQ-026 Packets held when reset asserts SHALL be discarded; the first accepted packet after reset appears one cycle later.

Configuration
REQ-027 Macro SWITCH_DROP_EN: when defined, rdy SHALL be tied to 1; a packet for a full FIFO SHALL be discarded and a per-port 16-bit saturating counter drop_cnt (output NUM_PORTS*16, reset 0) incremented.
REQ-028 Without SWITCH_DROP_EN, the drop_cnt port and its logic SHALL not exist and backpressure per REQ-017 SHALL apply.

Structure
REQ-029 Package switch_pkg SHALL hold the default parameter constants, the port-index-width constant function, and the packet struct {addr, data} typedef.
REQ-030 Sub-module switch_fifo (parametrised width and depth, push/pop/full/empty) SHALL be instantiated NUM_PORTS times via generate.

Verification
REQ-031 Reset, then addr=0x10 data=0xAAAA vld=1 for one cycle -> out_vld[0]=1 the next cycle with out_addr=0x10, out_data=0xAAAA; other out_vld stay 0.
REQ-032 Send addr 0x3F, 0x40, 0x80, 0xC0 back-to-back -> one packet each on ports 0,1,2,3, each one cycle after its acceptance.
REQ-033 out_rdy[2]=0, send 5 packets to 0x80 -> first 4 accepted, rdy=0 on the 5th; raise out_rdy[2] -> the 4 drain in order, then the 5th is accepted.
REQ-034 Port 1 full, simultaneous pop on port 1 and push to port 1 -> push refused, occupancy 3; push to port 0 in the same state -> accepted.
REQ-035 Assert rst for one cycle with 3 packets queued on port 3 -> out_vld=0 the next cycle, rdy=1, and no stale packet appears afterwards.
REQ-036 With SWITCH_DROP_EN, out_rdy[0]=0, send 6 packets to 0x00 -> rdy stays 1, 4 stored, drop_cnt for port 0 = 2.
